// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - rx_state_e        : receiver state encoding (IDLE, START, DATA, STOP)
//   - DATA_BITS         : payload width of one 8N1 character
//   - calc_clks_per_bit : rounded clock cycles per serial bit
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Rounded division so a baud rate that does not divide the clock evenly
  // lands on the nearest whole number of cycles per bit.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + (baud / 2)) / baud;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Byte-side interface of the UART receiver.
//   rx_data   : received byte, stable while rx_valid is high
//   rx_valid  : byte available
//   rx_ready  : consumer accepts (transfer on rx_valid & rx_ready at clk edge)
//   frame_err : one-cycle pulse, stop bit was sampled low
//   overrun   : sticky, a byte completed while the holding register was full
//   err_clr   : synchronous clear of overrun
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 err_clr;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready,
    input  err_clr
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready,
    output err_clr
  );

endinterface : uart_rx_if

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset
//   din      : asynchronous input
//   dout     : synchronised output (two cycles of latency)
// RESET_VAL sets the value both flops take in reset, so an idle-high line
// does not look like an edge when reset is released.
// -----------------------------------------------------------------------------
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_d;
  logic [1:0] sync_q;

  // Shift the raw input through the two-stage chain.
  always_comb begin
    sync_d = {sync_q[0], din};
  end

  // Synchroniser flops, both reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[1];

endmodule : uart_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a one-entry holding register on a valid/ready port.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   uart_rxd : serial line, idle high, asynchronous to clk
//   bus      : uart_rx_if.master (rx_data, rx_valid, rx_ready, frame_err,
//              overrun, err_clr)
// The line is synchronised first; every decision uses the synchronised value.
// The start bit is checked near its middle, then each data bit and the stop
// bit are sampled one bit period apart, so every sample lands mid-bit.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 1152000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      uart_rxd,
  uart_rx_if.master bus
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(clk_freq, uart_baud_rate);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // START occupies (CLKS_PER_BIT-1)/2 cycles: counter values 0 .. that-1.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(((CLKS_PER_BIT - 1) / 2) - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

  logic rxs;

  rx_state_e            state_d,     state_q;
  logic [CNT_W-1:0]     cnt_d,       cnt_q;
  logic [2:0]           bit_d,       bit_q;
  logic [DATA_BITS-1:0] shift_d,     shift_q;
  logic [DATA_BITS-1:0] rx_data_d,   rx_data_q;
  logic                 rx_valid_d,  rx_valid_q;
  logic                 frame_err_d, frame_err_q;
  logic                 overrun_d,   overrun_q;
  logic                 armed_d,     armed_q;
  logic                 xfer;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .din   (uart_rxd),
    .dout  (rxs)
  );

  // Next-state logic for the receive FSM, holding register and error flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    armed_d     = armed_q;

    xfer = rx_valid_q & bus.rx_ready;

    if (xfer) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    // Clear first so a same-cycle overrun event below takes priority.
    if (bus.err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        // After a framing error the line must be seen high before the next
        // falling edge counts, so a held break reports only once.
        if (rxs) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
        if (!rxs && armed_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (!rxs) begin
            state_d = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};  // LSB first
          if (bit_q == LAST_BIT) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            // Load when empty or when the current byte leaves this cycle.
            if (!rx_valid_q || xfer) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule : uart_rx
